// File: rtl/mem_responder.sv
// Word-addressed data memory that answers CPU MemRd/MemWr requests after a fixed
// number of wait states. Define MEM_ALIGN_CHECK_EN to flag and suppress misaligned accesses.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] Wd,
  output logic [31:0] Rd,
  output logic        Ready,
  output logic        Busy,
  output logic        Err
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  word_q;
  logic [31:0]        wdata_q;
  logic               isWrite_q;
  logic [31:0]        rd_q;
  logic               accept;
  logic               access;
  logic               misaligned;

  logic [31:0] mem [DEPTH];

  // Upper address bits alias; the byte offset only matters with the alignment check.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{Addr[31:ADDR_W+2], Addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      misaligned_q <= 1'b0;
    end else if (accept) begin
      misaligned_q <= (Addr[1:0] != 2'b00);
    end
  end

  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MemRd || MemWr) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          accept  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_RESP;
          access  = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    Ready = (state_q == ST_RESP);
    Busy  = (state_q != ST_IDLE);
    Err   = (state_q == ST_RESP) && misaligned;
  end

  // Request is captured once at acceptance; inputs are ignored until back in IDLE.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      word_q    <= '0;
      wdata_q   <= '0;
      isWrite_q <= 1'b0;
    end else if (accept) begin
      word_q    <= Addr[ADDR_W+1:2];
      wdata_q   <= Wd;
      isWrite_q <= MemWr;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd_q <= '0;
    end else if (access && !isWrite_q && !misaligned) begin
      rd_q <= mem[word_q];
    end
  end

  always_ff @(posedge Clock) begin
    if (access && isWrite_q && !misaligned) begin
      mem[word_q] <= wdata_q;
    end
  end

  assign Rd = rd_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: one instance with two wait states
// and one with none, checking latency, data, handshake, aliasing and reset behaviour.
module tb_mem_responder;

  logic        clock;
  logic        reset;
  logic        memRdA, memWrA, memRdB, memWrB;
  logic [31:0] addrA, wdA, addrB, wdB;
  logic [31:0] rdA, rdB;
  logic        readyA, busyA, errA, readyB, busyB, errB;

  int checks;
  int errors;

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dutA (
    .Clock(clock), .Reset(reset), .MemRd(memRdA), .MemWr(memWrA),
    .Addr(addrA), .Wd(wdA), .Rd(rdA), .Ready(readyA), .Busy(busyA), .Err(errA)
  );

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dutB (
    .Clock(clock), .Reset(reset), .MemRd(memRdB), .MemWr(memWrB),
    .Addr(addrB), .Wd(wdB), .Rd(rdB), .Ready(readyB), .Busy(busyB), .Err(errB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one request, hold it until Ready, and report latency, busy cycles, Err and Rd.
  task automatic applyStimulus(input bit sel, input bit rd, input bit wr,
                               input logic [31:0] addr, input logic [31:0] wd,
                               output int edges, output int busyCnt,
                               output logic err, output logic [31:0] rdVal);
    logic rdy;
    @(negedge clock);
    if (sel) begin memRdB = rd; memWrB = wr; addrB = addr; wdB = wd; end
    else     begin memRdA = rd; memWrA = wr; addrA = addr; wdA = wd; end
    edges   = 0;
    busyCnt = 0;
    err     = 1'b0;
    rdVal   = '0;
    rdy     = 1'b0;
    while (!rdy && edges < 20) begin
      @(posedge clock);
      #1;
      edges++;
      if (sel ? busyB : busyA) busyCnt++;
      rdy = sel ? readyB : readyA;
    end
    if (!rdy) checkOutput("ready_timeout", 32'd0, 32'd1);
    err   = sel ? errB : errA;
    rdVal = sel ? rdB : rdA;
    if (sel) begin memRdB = 1'b0; memWrB = 1'b0; end
    else     begin memRdA = 1'b0; memWrA = 1'b0; end
    @(posedge clock);
    #1;
    checkOutput("ready_single_cycle", {31'd0, sel ? readyB : readyA}, 32'd0);
  endtask

  initial begin
    int          edges, busyCnt, n;
    logic        err;
    logic [31:0] rdVal;

    checks = 0;
    errors = 0;
    memRdA = 0; memWrA = 0; addrA = 0; wdA = 0;
    memRdB = 0; memWrB = 0; addrB = 0; wdB = 0;
    reset  = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_busy",  {31'd0, busyA},  32'd0);
    checkOutput("reset_ready", {31'd0, readyA}, 32'd0);
    checkOutput("reset_err",   {31'd0, errA},   32'd0);
    checkOutput("reset_rd",    rdA,             32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Known content at 0x10, then a write to it interrupted by reset mid-WAIT.
    applyStimulus(0, 0, 1, 32'h10, 32'h77, edges, busyCnt, err, rdVal);
    applyStimulus(0, 1, 0, 32'h10, 32'h0, edges, busyCnt, err, rdVal);
    checkOutput("preload_rd", rdVal, 32'h77);
    @(negedge clock);
    memWrA = 1'b1; addrA = 32'h10; wdA = 32'h1;
    repeat (3) @(posedge clock);
    #2;
    reset  = 1'b1;
    memWrA = 1'b0;
    #1;
    checkOutput("midwait_reset_busy",  {31'd0, busyA},  32'd0);
    checkOutput("midwait_reset_ready", {31'd0, readyA}, 32'd0);
    checkOutput("midwait_reset_rd",    rdA,             32'd0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(0, 1, 0, 32'h10, 32'h0, edges, busyCnt, err, rdVal);
    checkOutput("dropped_write_rd", rdVal, 32'h77);

    // Basic write/read with two wait states.
    applyStimulus(0, 0, 1, 32'h10, 32'hCAFEF00D, edges, busyCnt, err, rdVal);
    checkOutput("wr_latency", edges, 32'd4);
    checkOutput("wr_busy_cycles", busyCnt, 32'd4);
    checkOutput("wr_err", {31'd0, err}, 32'd0);
    checkOutput("wr_rd_unchanged", rdVal, 32'h77);
    applyStimulus(0, 1, 0, 32'h10, 32'h0, edges, busyCnt, err, rdVal);
    checkOutput("rd_latency", edges, 32'd4);
    checkOutput("rd_busy_cycles", busyCnt, 32'd4);
    checkOutput("rd_data", rdVal, 32'hCAFEF00D);

    // Read and write together is a write.
    applyStimulus(0, 1, 1, 32'h8, 32'hA5A5A5A5, edges, busyCnt, err, rdVal);
    checkOutput("both_rd_unchanged", rdVal, 32'hCAFEF00D);
    applyStimulus(0, 1, 0, 32'h8, 32'h0, edges, busyCnt, err, rdVal);
    checkOutput("both_readback", rdVal, 32'hA5A5A5A5);

    // Held read: second acceptance right after returning to IDLE.
    @(negedge clock);
    memRdA = 1'b1; addrA = 32'h8;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!readyA && n < 20);
    checkOutput("held_first_latency", n, 32'd4);
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!readyA && n < 20);
    checkOutput("held_period", n, 32'd5);
    checkOutput("held_rd", rdA, 32'hA5A5A5A5);
    memRdA = 1'b0;
    @(posedge clock);
    #1;

    // Aliasing modulo 2^(ADDR_W+2).
    applyStimulus(0, 0, 1, 32'h400, 32'h11111111, edges, busyCnt, err, rdVal);
    applyStimulus(0, 1, 0, 32'h0, 32'h0, edges, busyCnt, err, rdVal);
    checkOutput("alias_wrap_rd", rdVal, 32'h11111111);
    applyStimulus(0, 0, 1, 32'h3FC, 32'h22, edges, busyCnt, err, rdVal);
    applyStimulus(0, 1, 0, 32'hFFFFFFFC, 32'h0, edges, busyCnt, err, rdVal);
    checkOutput("alias_high_rd", rdVal, 32'h22);

    // Misaligned write to word 4.
    applyStimulus(0, 0, 1, 32'h13, 32'hBAD, edges, busyCnt, err, rdVal);
    checkOutput("misaligned_latency", edges, 32'd4);
`ifdef MEM_ALIGN_CHECK_EN
    checkOutput("misaligned_err", {31'd0, err}, 32'd1);
    applyStimulus(0, 1, 0, 32'h10, 32'h0, edges, busyCnt, err, rdVal);
    checkOutput("misaligned_suppressed", rdVal, 32'hCAFEF00D);
`else
    checkOutput("misaligned_err", {31'd0, err}, 32'd0);
    applyStimulus(0, 1, 0, 32'h10, 32'h0, edges, busyCnt, err, rdVal);
    checkOutput("misaligned_stored", rdVal, 32'hBAD);
`endif
    checkOutput("aligned_err", {31'd0, err}, 32'd0);

    // Zero wait states.
    applyStimulus(1, 0, 1, 32'h4, 32'h12345678, edges, busyCnt, err, rdVal);
    checkOutput("w0_wr_latency", edges, 32'd2);
    applyStimulus(1, 1, 0, 32'h4, 32'h0, edges, busyCnt, err, rdVal);
    checkOutput("w0_rd_latency", edges, 32'd2);
    checkOutput("w0_busy_cycles", busyCnt, 32'd2);
    checkOutput("w0_rd_data", rdVal, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation timed out");
  end

endmodule
